// File: rtl/quant_pkg.sv
// quant_pkg: shared constants, zigzag scan table and FSM states for the quantizer.
package quant_pkg;
   localparam int QFIX      = 17;
   localparam int MAX_LEVEL = 2047;
   localparam logic [3:0] K_ZIGZAG [16] = '{4'd0, 4'd1, 4'd4, 4'd8, 4'd5, 4'd2, 4'd3, 4'd6,
                                           4'd9, 4'd12, 4'd13, 4'd10, 4'd7, 4'd11, 4'd14, 4'd15};
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/quant_lane.sv
// quant_lane: one coefficient through the two-stage quantize/dequantize datapath.
module quant_lane import quant_pkg::*; #(
   parameter int I_WIDTH  = 12,
   parameter int L_WIDTH  = 12,
   parameter int Q_WIDTH  = 16,
   parameter int IQ_WIDTH = 18,
   parameter int B_WIDTH  = 18,
   parameter int DQ_WIDTH = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en_i,
   input  logic [I_WIDTH-1:0]  coeff_i,
   input  logic [Q_WIDTH-1:0]  sharpen_i,
   input  logic [B_WIDTH-1:0]  zthresh_i,
   input  logic [IQ_WIDTH-1:0] iq_i,
   input  logic [B_WIDTH-1:0]  bias_i,
   input  logic [Q_WIDTH-1:0]  q_i,
   output logic [L_WIDTH-1:0]  level_o,
   output logic [DQ_WIDTH-1:0] dq_o
);
   localparam int A_W = Q_WIDTH + 1;
   localparam int P_W = A_W + IQ_WIDTH + 1;
   logic [I_WIDTH-1:0]  mag;
   logic [A_W-1:0]      a;
   logic [P_W-1:0]      p_d, p_q, lvl_full;
   logic                sign_q, pass_q;
   logic [Q_WIDTH-1:0]  q_q;
   logic [L_WIDTH-1:0]  mag_l;
   // unsigned magnitude: |-2^(I_WIDTH-1)| still fits I_WIDTH bits
   assign mag = coeff_i[I_WIDTH-1] ? -coeff_i : coeff_i;
   assign a   = A_W'(mag) + A_W'(sharpen_i);
   assign p_d = P_W'(a) * P_W'(iq_i) + P_W'(bias_i);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_q    <= '0;
         sign_q <= 1'b0;
         pass_q <= 1'b0;
         q_q    <= '0;
      end else if (en_i) begin
         p_q    <= p_d;
         sign_q <= coeff_i[I_WIDTH-1];
         pass_q <= P_W'(a) > P_W'(zthresh_i);
         q_q    <= q_i;
      end
   end
   assign lvl_full = p_q >> QFIX;
   assign mag_l    = (lvl_full > P_W'(MAX_LEVEL)) ? L_WIDTH'(MAX_LEVEL) : lvl_full[L_WIDTH-1:0];
   assign level_o  = !pass_q ? '0 : sign_q ? -mag_l : mag_l;
   assign dq_o     = DQ_WIDTH'($signed(level_o)) * DQ_WIDTH'(q_q);
endmodule

// File: rtl/quantize_block.sv
// quantize_block: 4x4 coefficient quantizer, four lanes per beat over four beats,
// levels out in zigzag order, dequantized coefficients in raster order.
module quantize_block import quant_pkg::*; #(
   parameter int I_WIDTH  = 12,
   parameter int L_WIDTH  = 12,
   parameter int Q_WIDTH  = 16,
   parameter int IQ_WIDTH = 18,
   parameter int B_WIDTH  = 18,
   parameter int DQ_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [16*I_WIDTH-1:0]  coeff,
   input  logic [16*Q_WIDTH-1:0]  q,
   input  logic [16*Q_WIDTH-1:0]  sharpen,
   input  logic [16*IQ_WIDTH-1:0] iq,
   input  logic [16*B_WIDTH-1:0]  bias,
   input  logic [16*B_WIDTH-1:0]  zthresh,
   output logic [16*L_WIDTH-1:0]  level,
   output logic [16*DQ_WIDTH-1:0] dq,
   output logic                   nz,
   output logic [3:0]             last,
   output logic                   busy,
   output logic                   done
);
   state_t                 state_q, state_d;
   logic [1:0]             beat_q, beat_d, b1_q;
   logic                   v1_q, accept;
   logic [16*I_WIDTH-1:0]  coeff_q;
   logic [16*Q_WIDTH-1:0]  q_q, sharpen_q;
   logic [16*IQ_WIDTH-1:0] iq_q;
   logic [16*B_WIDTH-1:0]  bias_q, zthresh_q;
   logic [16*L_WIDTH-1:0]  level_q, level_d;
   logic [16*DQ_WIDTH-1:0] dq_q, dq_d;
   logic                   nz_q, nz_d, nz_acc_q, nz_acc_d, nz_acc_n, done_q;
   logic [3:0]             last_q, last_d, last_acc_q, last_acc_d, last_acc_n, n;
   logic [L_WIDTH-1:0]     l_level [4];
   logic [DQ_WIDTH-1:0]    l_dq [4];
   for (genvar g = 0; g < 4; g++) begin : g_lane
      logic [3:0] j;
      assign j = K_ZIGZAG[{beat_q, 2'(g)}];
      quant_lane #(
         .I_WIDTH(I_WIDTH), .L_WIDTH(L_WIDTH), .Q_WIDTH(Q_WIDTH),
         .IQ_WIDTH(IQ_WIDTH), .B_WIDTH(B_WIDTH), .DQ_WIDTH(DQ_WIDTH)
      ) u_lane (
         .clk       (clk),
         .rst_n     (rst_n),
         .en_i      (state_q == RUN),
         .coeff_i   (coeff_q[j*I_WIDTH +: I_WIDTH]),
         .sharpen_i (sharpen_q[j*Q_WIDTH +: Q_WIDTH]),
         .zthresh_i (zthresh_q[j*B_WIDTH +: B_WIDTH]),
         .iq_i      (iq_q[j*IQ_WIDTH +: IQ_WIDTH]),
         .bias_i    (bias_q[j*B_WIDTH +: B_WIDTH]),
         .q_i       (q_q[j*Q_WIDTH +: Q_WIDTH]),
         .level_o   (l_level[g]),
         .dq_o      (l_dq[g])
      );
   end
   // a start in DRAIN is taken so a new block can begin on the done edge
   assign accept  = start && (state_q == IDLE || state_q == DRAIN);
   assign state_d = accept ? RUN : (state_q == RUN) ? ((beat_q == 2'd3) ? DRAIN : RUN) : IDLE;
   assign beat_d  = (state_q == RUN) ? beat_q + 2'd1 : 2'd0;
   always_comb begin
      level_d    = level_q;
      dq_d       = dq_q;
      nz_acc_n   = nz_acc_q;
      last_acc_n = last_acc_q;
      n          = '0;
      if (v1_q) begin
         for (int l = 0; l < 4; l++) begin
            n = {b1_q, 2'(l)};
            level_d[n*L_WIDTH +: L_WIDTH]            = l_level[l];
            dq_d[K_ZIGZAG[n]*DQ_WIDTH +: DQ_WIDTH]   = l_dq[l];
            if (l_level[l] != '0) begin
               nz_acc_n   = 1'b1;
               last_acc_n = n;
            end
         end
      end
   end
   assign nz_acc_d   = accept ? 1'b0 : nz_acc_n;
   assign last_acc_d = accept ? 4'd0 : last_acc_n;
   assign nz_d       = (state_q == DRAIN) ? nz_acc_n : nz_q;
   assign last_d     = (state_q == DRAIN) ? last_acc_n : last_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         beat_q     <= '0;
         b1_q       <= '0;
         v1_q       <= 1'b0;
         coeff_q    <= '0;
         q_q        <= '0;
         sharpen_q  <= '0;
         iq_q       <= '0;
         bias_q     <= '0;
         zthresh_q  <= '0;
         level_q    <= '0;
         dq_q       <= '0;
         nz_q       <= 1'b0;
         last_q     <= '0;
         nz_acc_q   <= 1'b0;
         last_acc_q <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         beat_q     <= beat_d;
         b1_q       <= beat_q;
         v1_q       <= state_q == RUN;
         coeff_q    <= accept ? coeff : coeff_q;
         q_q        <= accept ? q : q_q;
         sharpen_q  <= accept ? sharpen : sharpen_q;
         iq_q       <= accept ? iq : iq_q;
         bias_q     <= accept ? bias : bias_q;
         zthresh_q  <= accept ? zthresh : zthresh_q;
         level_q    <= level_d;
         dq_q       <= dq_d;
         nz_q       <= nz_d;
         last_q     <= last_d;
         nz_acc_q   <= nz_acc_d;
         last_acc_q <= last_acc_d;
         done_q     <= state_q == DRAIN;
      end
   end
   assign level = level_q;
   assign dq    = dq_q;
   assign nz    = nz_q;
   assign last  = last_q;
   assign busy  = state_q != IDLE;
   assign done  = done_q;
endmodule
